// File: rtl/butterfly_twiddle_pipe.sv
// Radix-2 DIT butterfly with twiddle multiply: x0 = a + b*W, x1 = a - b*W.
// Four-stage pipeline under one global enable; trivial twiddles bypass the multiplier.
module butterfly_twiddle_pipe #(
  parameter int LOG2N     = 6,
  parameter int DW        = 16,
  parameter int TW_W      = 17,
  parameter int OUT_GROW  = 0,
  parameter int USE_ROUND = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DW-1:0]         in_a_i,
  input  logic signed [DW-1:0]         in_a_q,
  input  logic signed [DW-1:0]         in_b_i,
  input  logic signed [DW-1:0]         in_b_q,
  input  logic [LOG2N-2:0]             in_k,
  input  logic                         in_inv,
  input  logic                         in_scale,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DW+OUT_GROW-1:0] out_x0_i,
  output logic signed [DW+OUT_GROW-1:0] out_x0_q,
  output logic signed [DW+OUT_GROW-1:0] out_x1_i,
  output logic signed [DW+OUT_GROW-1:0] out_x1_q,
  output logic                         out_sat,
  output logic                         sat_sticky,
  input  logic                         sat_clr
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int KW   = LOG2N - 1;
  localparam int PW   = DW + TW_W;
  localparam int SW   = PW + 1;
  localparam int SH   = TW_W - 2;
  localparam int BW   = DW + 1;
  localparam int AW   = DW + 2;
  localparam int OW   = DW + OUT_GROW;

  localparam logic [KW-1:0]        K_Q   = KW'(N / 4);
  localparam logic signed [SW-1:0] RND_M = (USE_ROUND != 0) ? SW'(1 << (SH - 1)) : SW'(0);
  localparam logic signed [AW-1:0] RND_S = (USE_ROUND != 0) ? AW'(1) : AW'(0);
  localparam logic signed [AW-1:0] OMAX  = AW'((1 << (OW - 1)) - 1);
  localparam logic signed [AW-1:0] OMIN  = AW'(-(1 << (OW - 1)));

  typedef struct packed {
    logic signed [DW-1:0] ai;
    logic signed [DW-1:0] aq;
    logic signed [DW-1:0] bi;
    logic signed [DW-1:0] bq;
    logic                 inv;
    logic                 scale;
    logic                 k0;
    logic                 kq;
  } s_ctl_t;

  // Quarter-wave Taylor series evaluated at elaboration; second quadrant by symmetry.
  function automatic logic signed [TW_W-1:0] tw_val(input int k, input bit want_sin);
    real x, term, c, s, v;
    int  kk, r;
    kk   = (k > N / 4) ? HALF - k : k;
    x    = 6.283185307179586 * real'(kk) / real'(N);
    term = 1.0;
    c    = 0.0;
    s    = 0.0;
    for (int n = 0; n < 24; n++) begin
      if (n > 0) term = term * x / real'(n);
      case (n % 4)
        0:       c = c + term;
        1:       s = s + term;
        2:       c = c - term;
        default: s = s - term;
      endcase
    end
    if (k > N / 4) c = -c;
    v = (want_sin ? s : c) * real'(1 << SH);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return TW_W'(r);
  endfunction

  function automatic logic [OW:0] sat_f(input logic signed [AW-1:0] v);
    if (v > OMAX)      return {1'b1, OMAX[OW-1:0]};
    else if (v < OMIN) return {1'b1, OMIN[OW-1:0]};
    else               return {1'b0, v[OW-1:0]};
  endfunction

  logic signed [TW_W-1:0] cos_tab [HALF];
  logic signed [TW_W-1:0] sin_tab [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam logic signed [TW_W-1:0] C = tw_val(g, 1'b0);
    localparam logic signed [TW_W-1:0] S = tw_val(g, 1'b1);
    assign cos_tab[g] = C;
    assign sin_tab[g] = S;
  end

  logic                   ce;
  logic [4:1]             vld_pipe_q;
  s_ctl_t                 s1_d, s1_q, s2_q;
  logic signed [TW_W-1:0] cos_q, sin_q;
  logic signed [PW-1:0]   pci_d, psi_d, pcq_d, psq_d;
  logic signed [PW-1:0]   pci_q, psi_q, pcq_q, psq_q;
  logic signed [BW-1:0]   bwi_d, bwq_d, bwi_q, bwq_q;
  logic signed [DW-1:0]   s3_ai_q, s3_aq_q;
  logic                   s3_scale_q;
  logic signed [AW-1:0]   s4_sum [4];
  logic [OW:0]            s4_sat [4];
  logic                   sat_any;
  logic signed [OW-1:0]   x_q [4];
  logic                   out_sat_q, sat_sticky_q;

  assign ce       = !vld_pipe_q[4] || out_ready;
  assign in_ready = ce;

  always_comb begin
    s1_d       = '0;
    s1_d.ai    = in_a_i;
    s1_d.aq    = in_a_q;
    s1_d.bi    = in_b_i;
    s1_d.bq    = in_b_q;
    s1_d.inv   = in_inv;
    s1_d.scale = in_scale;
    s1_d.k0    = (in_k == '0);
    s1_d.kq    = (in_k == K_Q);
  end

  always_comb begin
    pci_d = PW'($signed(s1_q.bi)) * PW'(cos_q);
    psi_d = PW'($signed(s1_q.bi)) * PW'(sin_q);
    pcq_d = PW'($signed(s1_q.bq)) * PW'(cos_q);
    psq_d = PW'($signed(s1_q.bq)) * PW'(sin_q);
  end

  always_comb begin
    logic signed [SW-1:0] ti, tq;
    logic signed [BW-1:0] bi_x, bq_x;
    bi_x = BW'($signed(s2_q.bi));
    bq_x = BW'($signed(s2_q.bq));
    // Inverse twiddle is the conjugate: the sin terms flip sign.
    if (!s2_q.inv) begin
      ti = SW'(pci_q) + SW'(psq_q);
      tq = SW'(pcq_q) - SW'(psi_q);
    end else begin
      ti = SW'(pci_q) - SW'(psq_q);
      tq = SW'(pcq_q) + SW'(psi_q);
    end
    bwi_d = BW'((ti + RND_M) >>> SH);
    bwq_d = BW'((tq + RND_M) >>> SH);
    if (s2_q.k0) begin
      bwi_d = bi_x;
      bwq_d = bq_x;
    end else if (s2_q.kq) begin
      bwi_d = s2_q.inv ? -bq_x : bq_x;
      bwq_d = s2_q.inv ? bi_x  : -bi_x;
    end
  end

  always_comb begin
    s4_sum[0] = AW'(s3_ai_q) + AW'(bwi_q);
    s4_sum[1] = AW'(s3_aq_q) + AW'(bwq_q);
    s4_sum[2] = AW'(s3_ai_q) - AW'(bwi_q);
    s4_sum[3] = AW'(s3_aq_q) - AW'(bwq_q);
    for (int j = 0; j < 4; j++) begin
      if (s3_scale_q) s4_sum[j] = (s4_sum[j] + RND_S) >>> 1;
      s4_sat[j] = sat_f(s4_sum[j]);
    end
    sat_any = s4_sat[0][OW] | s4_sat[1][OW] | s4_sat[2][OW] | s4_sat[3][OW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q   <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      cos_q        <= '0;
      sin_q        <= '0;
      pci_q        <= '0;
      psi_q        <= '0;
      pcq_q        <= '0;
      psq_q        <= '0;
      bwi_q        <= '0;
      bwq_q        <= '0;
      s3_ai_q      <= '0;
      s3_aq_q      <= '0;
      s3_scale_q   <= 1'b0;
      x_q          <= '{default: '0};
      out_sat_q    <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      if (ce) begin
        vld_pipe_q <= {vld_pipe_q[3:1], in_valid};
        s1_q       <= s1_d;
        cos_q      <= cos_tab[in_k];
        sin_q      <= sin_tab[in_k];
        s2_q       <= s1_q;
        pci_q      <= pci_d;
        psi_q      <= psi_d;
        pcq_q      <= pcq_d;
        psq_q      <= psq_d;
        bwi_q      <= bwi_d;
        bwq_q      <= bwq_d;
        s3_ai_q    <= s2_q.ai;
        s3_aq_q    <= s2_q.aq;
        s3_scale_q <= s2_q.scale;
        for (int j = 0; j < 4; j++) x_q[j] <= s4_sat[j][OW-1:0];
        out_sat_q  <= vld_pipe_q[3] & sat_any;
      end
      // A saturating result landing this cycle beats a simultaneous clear.
      if (ce && vld_pipe_q[3] && sat_any) sat_sticky_q <= 1'b1;
      else if (sat_clr)                   sat_sticky_q <= 1'b0;
    end
  end

  assign out_valid  = vld_pipe_q[4];
  assign out_x0_i   = x_q[0];
  assign out_x0_q   = x_q[1];
  assign out_x1_i   = x_q[2];
  assign out_x1_q   = x_q[3];
  assign out_sat    = out_sat_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_butterfly_twiddle_pipe.sv
// Bench for butterfly_twiddle_pipe: vector table plus scoreboard, with a floor-rounding twin instance.
module tb_butterfly_twiddle_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_inv, in_scale, out_ready, sat_clr;
  logic signed [15:0] in_a_i, in_a_q, in_b_i, in_b_q;
  logic [4:0] in_k;
  logic in_ready, out_valid, out_sat, sat_sticky;
  logic signed [15:0] out_x0_i, out_x0_q, out_x1_i, out_x1_q;
  logic fl_in_ready, fl_out_valid, fl_out_sat, fl_sat_sticky;
  logic signed [15:0] fl_x0_i, fl_x0_q, fl_x1_i, fl_x1_q;

  always #5 clk = ~clk;

  butterfly_twiddle_pipe #(.LOG2N(6), .DW(16), .TW_W(17), .OUT_GROW(0), .USE_ROUND(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_i(in_a_i), .in_a_q(in_a_q), .in_b_i(in_b_i), .in_b_q(in_b_q),
    .in_k(in_k), .in_inv(in_inv), .in_scale(in_scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0_i(out_x0_i), .out_x0_q(out_x0_q), .out_x1_i(out_x1_i), .out_x1_q(out_x1_q),
    .out_sat(out_sat), .sat_sticky(sat_sticky), .sat_clr(sat_clr));

  butterfly_twiddle_pipe #(.LOG2N(6), .DW(16), .TW_W(17), .OUT_GROW(0), .USE_ROUND(0)) dut_fl (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(fl_in_ready),
    .in_a_i(in_a_i), .in_a_q(in_a_q), .in_b_i(in_b_i), .in_b_q(in_b_q),
    .in_k(in_k), .in_inv(in_inv), .in_scale(in_scale),
    .out_valid(fl_out_valid), .out_ready(out_ready),
    .out_x0_i(fl_x0_i), .out_x0_q(fl_x0_q), .out_x1_i(fl_x1_i), .out_x1_q(fl_x1_q),
    .out_sat(fl_out_sat), .sat_sticky(fl_sat_sticky), .sat_clr(sat_clr));

  typedef struct { int x0i, x0q, x1i, x1q; bit sat; } res_t;
  typedef struct { int ai, aq, bi, bq, k; bit inv, scale; res_t exp; } vec_t;
  typedef struct { res_t r; res_t rf; int cyc; bit lat; } sb_t;

  sb_t  sb[$];
  int   checks = 0, failures = 0, cyc = 0;
  res_t cur_exp, cur_fl;
  bit   cur_lat;
  vec_t tv[11];
  vec_t rv[40];
  int   ks[7] = '{0, 4, 8, 12, 16, 24, 28};

  // Reference model: Q15 twiddles for the k values the bench uses.
  function automatic res_t model(int ai, int aq, int bi, int bq, int k, bit inv, bit scale, bit rnd);
    longint c, s, ti, tq, bwi, bwq;
    longint r[4];
    res_t   o;
    c = 0; s = 0;
    if (k == 0) begin
      bwi = bi; bwq = bq;
    end else if (k == 16) begin
      bwi = inv ? -bq : bq;
      bwq = inv ? bi : -bi;
    end else begin
      case (k)
        4:  begin c = 30274;  s = 12540; end
        8:  begin c = 23170;  s = 23170; end
        12: begin c = 12540;  s = 30274; end
        24: begin c = -23170; s = 23170; end
        28: begin c = -30274; s = 12540; end
        default: begin c = 0; s = 0; end
      endcase
      ti  = inv ? bi * c - bq * s : bi * c + bq * s;
      tq  = inv ? bq * c + bi * s : bq * c - bi * s;
      bwi = rnd ? (ti + 16384) >>> 15 : ti >>> 15;
      bwq = rnd ? (tq + 16384) >>> 15 : tq >>> 15;
    end
    r[0] = ai + bwi; r[1] = aq + bwq; r[2] = ai - bwi; r[3] = aq - bwq;
    o.sat = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (scale) r[j] = rnd ? (r[j] + 1) >>> 1 : r[j] >>> 1;
      if (r[j] > 32767)  begin r[j] = 32767;  o.sat = 1'b1; end
      if (r[j] < -32768) begin r[j] = -32768; o.sat = 1'b1; end
    end
    o.x0i = int'(r[0]); o.x0q = int'(r[1]); o.x1i = int'(r[2]); o.x1q = int'(r[3]);
    return o;
  endfunction

  task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_sample(vec_t v);
    in_a_i = 16'(v.ai); in_a_q = 16'(v.aq); in_b_i = 16'(v.bi); in_b_q = 16'(v.bq);
    in_k = 5'(v.k); in_inv = v.inv; in_scale = v.scale;
    cur_exp = v.exp;
    cur_fl  = model(v.ai, v.aq, v.bi, v.bq, v.k, v.inv, v.scale, 1'b0);
  endtask

  // One clock: compare any output taken this cycle, record any input taken, then advance.
  task automatic step(output bit fired);
    sb_t e;
    #1;
    fired = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_out actual=out_valid expected=no_output (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("x0_i", out_x0_i, e.r.x0i);
        chk("x0_q", out_x0_q, e.r.x0q);
        chk("x1_i", out_x1_i, e.r.x1i);
        chk("x1_q", out_x1_q, e.r.x1q);
        chk("out_sat", out_sat, e.r.sat);
        chk("floor_x", {fl_x0_i, fl_x0_q, fl_x1_i, fl_x1_q},
            {16'(e.rf.x0i), 16'(e.rf.x0q), 16'(e.rf.x1i), 16'(e.rf.x1q)});
        if (e.lat) chk("latency", cyc - e.cyc, 4);
      end
    end
    if (fired) begin
      e.r = cur_exp; e.rf = cur_fl; e.cyc = cyc; e.lat = cur_lat;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    bit f;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) step(f);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit f;
    int i, cnt;
    logic [63:0] held;

    tv[0]  = '{100, 50, 20, -10, 0, 1'b0, 1'b0, '{120, 40, 80, 60, 1'b0}};
    tv[1]  = '{0, 0, 1000, 0, 16, 1'b0, 1'b0, '{0, -1000, 0, 1000, 1'b0}};
    tv[2]  = '{0, 0, 1000, 0, 16, 1'b1, 1'b0, '{0, 1000, 0, -1000, 1'b0}};
    tv[3]  = '{0, 0, 1000, 0, 8, 1'b0, 1'b0, '{707, -707, -707, 707, 1'b0}};
    tv[4]  = '{32767, 0, 32767, 0, 0, 1'b0, 1'b0, '{32767, 0, 0, 0, 1'b1}};
    tv[5]  = '{32767, 0, 32767, 0, 0, 1'b0, 1'b1, '{32767, 0, 0, 0, 1'b0}};
    tv[6]  = '{-32768, -32768, -32768, 32767, 0, 1'b0, 1'b0, '{-32768, -1, 0, -32768, 1'b1}};
    tv[7]  = '{0, 0, -32768, 0, 16, 1'b0, 1'b0, '{0, 32767, 0, -32768, 1'b1}};
    tv[8]  = '{10, -20, 0, 1000, 8, 1'b1, 1'b0, '{-697, 687, 717, -727, 1'b0}};
    tv[9]  = '{0, 0, 1000, 0, 24, 1'b0, 1'b0, '{-707, -707, 707, 707, 1'b0}};
    tv[10] = '{0, 0, 2000, -3000, 4, 1'b0, 1'b1, '{350, -1768, -350, 1769, 1'b0}};

    for (int n = 0; n < 40; n++) begin
      rv[n].ai = int'($urandom_range(0, 65535)) - 32768;
      rv[n].aq = int'($urandom_range(0, 65535)) - 32768;
      rv[n].bi = int'($urandom_range(0, 65535)) - 32768;
      rv[n].bq = int'($urandom_range(0, 65535)) - 32768;
      rv[n].k = ks[$urandom_range(0, 6)];
      rv[n].inv = 1'($urandom_range(0, 1));
      rv[n].scale = 1'($urandom_range(0, 1));
      rv[n].exp = model(rv[n].ai, rv[n].aq, rv[n].bi, rv[n].bq, rv[n].k, rv[n].inv, rv[n].scale, 1'b1);
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0; cur_lat = 1'b0;
    in_a_i = '0; in_a_q = '0; in_b_i = '0; in_b_q = '0; in_k = '0; in_inv = 1'b0; in_scale = 1'b0;
    cur_exp = '{0, 0, 0, 0, 1'b0}; cur_fl = cur_exp;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_x0_i, out_x0_q, out_x1_i, out_x1_q}, 0);
    chk("rst_sat", {out_sat, sat_sticky}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table, streamed back to back
    cur_lat = 1'b1;
    for (int n = 0; n < 11; n++) begin
      set_sample(tv[n]);
      in_valid = 1'b1;
      step(f);
    end
    drain();
    chk("sticky_set", sat_sticky, 1);
    sat_clr = 1'b1;
    step(f);
    sat_clr = 1'b0;
    chk("sticky_clr", sat_sticky, 0);

    // sat_clr held while a saturating result lands: set must win
    sat_clr = 1'b1;
    set_sample(tv[4]);
    in_valid = 1'b1;
    step(f);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) step(f);
    #1;
    chk("prio_out_valid", out_valid, 1);
    chk("prio_sticky", sat_sticky, 1);
    step(f);
    step(f);
    chk("prio_clear_after", sat_sticky, 0);
    sat_clr = 1'b0;

    // 8 samples with a 3-cycle output stall mid-stream
    cur_lat = 1'b0;
    held = '0;
    i = 0;
    for (int t = 0; t < 60 && i < 8; t++) begin
      out_ready = !(t >= 5 && t <= 7);
      set_sample(rv[i]);
      in_valid = 1'b1;
      #1;
      if (t == 5) held = {out_valid, out_x0_i, out_x0_q, out_x1_i, out_x1_q[14:0]};
      if (t >= 5 && t <= 7) chk("stall_in_ready", in_ready, 0);
      if (t > 5 && t <= 7)
        chk("stall_hold", {out_valid, out_x0_i, out_x0_q, out_x1_i, out_x1_q[14:0]}, held);
      step(f);
      if (f) i++;
    end
    chk("stall_accepted", i, 8);
    drain();

    // Random backpressure over 32 more samples
    i = 8;
    for (int t = 0; t < 400 && i < 40; t++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      set_sample(rv[i]);
      in_valid = 1'b1;
      step(f);
      if (f) i++;
    end
    chk("random_accepted", i, 40);
    drain();

    // Reset with three samples in flight, head one stalled at the output
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_sample(tv[n == 0 ? 0 : 8 + n]);
      in_valid = 1'b1;
      step(f);
    end
    in_valid = 1'b0;
    step(f);
    #1;
    chk("preflush_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_outputs", {out_x0_i, out_x0_q, out_x1_i, out_x1_q}, 0);
    chk("flush_sat", {out_sat, sat_sticky}, 0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      #1;
      if (out_valid) cnt++;
      step(f);
    end
    chk("post_reset_quiet", cnt, 0);
    cur_lat = 1'b1;
    set_sample(tv[3]);
    in_valid = 1'b1;
    step(f);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/butterfly_twiddle_pipe.md
BUTTERFLY_TWIDDLE_PIPE -- requirements
Module: butterfly_twiddle_pipe

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  LOG2N  6  log2 of FFT size N; legal range 2..10.
  DW  16  input sample width, signed two's complement.
  TW_W  17  twiddle width; 1.0 is stored as 2^(TW_W-2).
  OUT_GROW  0  0 or 1; output width OW = DW+OUT_GROW.
  USE_ROUND  1  1 = round-half-up at every right shift; 0 = floor.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on the rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  in_valid  in  1  input sample present.
  in_ready  out  1  input accepted when in_valid && in_ready.
  in_a_i, in_a_q  in  DW  butterfly top operand a.
  in_b_i, in_b_q  in  DW  butterfly bottom operand b.
  in_k  in  max(LOG2N-1,1)  twiddle index k, 0..N/2-1.
  in_inv  in  1  0 = forward (W = e^-j2πk/N), 1 = inverse (conj W).
  in_scale  in  1  1 = divide butterfly results by 2.
  out_valid  out  1  result present.
  out_ready  in  1  downstream accepts.
  out_x0_i, out_x0_q  out  OW  a + b·W.
  out_x1_i, out_x1_q  out  OW  a − b·W.
  out_sat  out  1  saturation occurred on this result.
  sat_sticky  out  1  OR of out_sat since reset or sat_clr.
  sat_clr  in  1  synchronous clear of sat_sticky.

Function
REQ-003 SHALL have four pipeline stages with a fixed latency of 4 cycles from an accepted input to out_valid when there is no stall.
- S1: register operands and controls; read the cos/sin table (N/2 entries of cos(2πk/N) and sin(2πk/N), loaded from a hex file named twN.mem).
- S2: four signed DW×TW_W products.
- S3: form b·W and shift it right by TW_W-2, rounding per USE_ROUND, to width DW+1.
- S4: butterfly add/subtract, optional scale, saturate, and register the outputs.
REQ-004 SHALL compute b·W as follows.
- Forward: bW_i = b_i·cos + b_q·sin; bW_q = b_q·cos − b_i·sin.
- Inverse: the sin terms change sign.
REQ-005 SHALL bypass the multiplier for trivial twiddles, so these results are exact.
- k=0: bW = b.
- k=N/4, forward: bW = (b_q, −b_i).
- k=N/4, inverse: bW = (−b_q, b_i).
REQ-006 SHALL form the sums at width DW+2; when in_scale=1 it SHALL shift them arithmetically right by 1, rounding per USE_ROUND.
REQ-007 SHALL saturate each of the four results to the OW signed range, and SHALL set out_sat when any of them clipped.
REQ-008 SHALL advance every stage only when ce = !out_valid || out_ready, and SHALL drive in_ready = ce combinationally.
REQ-009 SHALL carry a valid bit per stage; bubbles SHALL propagate without producing outputs.
REQ-010 SHALL hold the outputs and out_valid stable while out_valid && !out_ready.
REQ-011 SHALL lose, duplicate and reorder no samples under any out_ready pattern.
REQ-012 SHALL let in_inv and in_scale take effect per sample, travelling with the data.
REQ-013 SHALL give set priority over sat_clr when an out_sat result is accepted in the same cycle.
REQ-014 SHALL treat an in_k value of N/2 or above as k mod N/2.
REQ-015 SHALL degenerate to the trivial cases only when LOG2N=2 (k in {0,1}), with no table file read.

Reset
REQ-016 SHALL, while rst_n=0 (asynchronous), clear all stage valid bits, out_valid, out_sat and sat_sticky, and drive all data outputs to 0.
REQ-017 SHALL discard any samples in flight at reset; after rst_n rises, out_valid SHALL stay 0 until 4 cycles after the first accepted input.

Verification
REQ-018 SHALL be covered by these directed scenarios (DW=16, LOG2N=6, TW_W=17, OUT_GROW=0, USE_ROUND=1, out_ready=1 unless stated):
- k=0, a=(100,50), b=(20,−10), scale 0 -> after 4 cycles x0=(120,40), x1=(80,60), out_sat=0.
- k=16, forward, a=(0,0), b=(1000,0) -> x0=(0,−1000), x1=(0,1000); the same inputs with inv=1 -> x0=(0,1000), x1=(0,−1000).
- k=8, forward, a=0, b=(1000,0), table cos=sin=23170 -> x0=(707,−707); with USE_ROUND=0 -> x0=(707,−708).
- k=0, a=b=(32767,0), scale 0 -> x0_i=32767, x1_i=0, out_sat=1, sat_sticky=1; the same inputs with scale 1 -> x0_i=32767, out_sat=0; sat_clr pulse -> sat_sticky=0.
- Stream 8 samples back to back, out_ready low for 3 cycles mid-stream -> in_ready low during the stall, outputs held, all 8 results correct and in order.
- Assert rst_n low with 3 samples in flight -> out_valid=0 and outputs=0 immediately; none of those 3 samples appears after release.
